// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB states and
// drives every datapath mux and enable, with trap path and retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned STATE_W = 5,
    parameter int unsigned CNT_W   = 32,
    parameter bit          TRAP_EN = 1'b1,
    parameter bit          EXT_OPS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        Inst_in,
    input  logic               zero,
    input  logic               overflow,
    output logic [STATE_W-1:0] state_out,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               Exception,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_JAL      = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Where an unrecognised opcode goes: trap, or straight back to fetch as a no-op.
    localparam state_t ILLEGAL_NEXT = TRAP_EN ? S_TRAP : S_FETCH;

    state_t     state, next_state;
    logic [5:0] opcode;
    logic       retire;

    assign opcode    = Inst_in[31:26];
    assign state_out = STATE_W'(state);

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state = S_R_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEM_ADDR;
                    OP_BEQ:        next_state = S_BEQ;
                    OP_J:          next_state = S_JUMP;
                    OP_BNE:        next_state = EXT_OPS ? S_BNE    : ILLEGAL_NEXT;
                    OP_ADDI:       next_state = EXT_OPS ? S_I_EXEC : ILLEGAL_NEXT;
                    OP_JAL:        next_state = EXT_OPS ? S_JAL    : ILLEGAL_NEXT;
                    default:       next_state = ILLEGAL_NEXT;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   next_state = S_MEM_WB;
            S_R_EXEC:   next_state = (TRAP_EN && overflow) ? S_TRAP : S_R_WB;
            S_I_EXEC:   next_state = (TRAP_EN && overflow) ? S_TRAP : S_I_WB;
            default:    next_state = S_FETCH;
        endcase
    end

    // A return to FETCH from DECODE is the illegal no-op; from TRAP is an abort.
    assign retire = (next_state == S_FETCH) && (state != S_DECODE) && (state != S_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    // Enables stay low throughout reset so PC, IR and memory are untouched.
    always_comb begin
        PCEn      = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        Exception = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSource  = 2'b00;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCEn    = 1'b1;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                end
                S_I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_I_WB:     RegWrite = 1'b1;
                S_BEQ, S_BNE: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b01;
                    PCSource = 2'b01;
                    PCEn     = (state == S_BEQ) ? zero : !zero;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCEn     = 1'b1;
                end
                S_JAL: begin
                    PCSource = 2'b10;
                    PCEn     = 1'b1;
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                S_TRAP: begin
                    PCSource  = 2'b11;
                    PCEn      = 1'b1;
                    Exception = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a full-featured instance and one
// with traps and extended opcodes disabled, sharing clock and reset.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst[2];
    logic        zero_in[2];
    logic        ovf_in[2];

    logic [4:0]  st_out[2];
    logic [31:0] ret_out[2];
    logic [17:0] ctl[2];

    logic        pcen[2], iord[2], mrd[2], mwr[2], irw[2], rw[2], exc[2], srca[2];
    logic [1:0]  rdst[2], m2r[2], srcb[2], aop[2], psrc[2];

    typedef struct {
        logic [4:0]  st;
        logic [17:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_ret[2];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(5), .CNT_W(32), .TRAP_EN(1'b1), .EXT_OPS(1'b1)) dut (
        .clk(clk), .rst(rst), .Inst_in(inst[0]), .zero(zero_in[0]), .overflow(ovf_in[0]),
        .state_out(st_out[0]), .PCEn(pcen[0]), .IorD(iord[0]), .MemRead(mrd[0]),
        .MemWrite(mwr[0]), .IRWrite(irw[0]), .RegWrite(rw[0]), .Exception(exc[0]),
        .RegDst(rdst[0]), .MemtoReg(m2r[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
        .ALUOp(aop[0]), .PCSource(psrc[0]), .instret(ret_out[0])
    );

    multicycle_controller #(.STATE_W(5), .CNT_W(32), .TRAP_EN(1'b0), .EXT_OPS(1'b0)) dut_basic (
        .clk(clk), .rst(rst), .Inst_in(inst[1]), .zero(zero_in[1]), .overflow(ovf_in[1]),
        .state_out(st_out[1]), .PCEn(pcen[1]), .IorD(iord[1]), .MemRead(mrd[1]),
        .MemWrite(mwr[1]), .IRWrite(irw[1]), .RegWrite(rw[1]), .Exception(exc[1]),
        .RegDst(rdst[1]), .MemtoReg(m2r[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
        .ALUOp(aop[1]), .PCSource(psrc[1]), .instret(ret_out[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_ctl
        assign ctl[g] = {pcen[g], iord[g], mrd[g], mwr[g], irw[g], rw[g], exc[g],
                         rdst[g], m2r[g], srca[g], srcb[g], aop[g], psrc[g]};
    end

    // Reference control word for each state, straight from the output table.
    function automatic logic [17:0] ctl_of(input logic [3:0] st, input logic z);
        logic       p_en, p_iord, p_mrd, p_mwr, p_irw, p_rw, p_exc, p_srca;
        logic [1:0] p_rdst, p_m2r, p_srcb, p_aop, p_psrc;
        {p_en, p_iord, p_mrd, p_mwr, p_irw, p_rw, p_exc, p_srca} = '0;
        {p_rdst, p_m2r, p_srcb, p_aop, p_psrc} = '0;
        case (st)
            4'd0:  begin p_mrd = 1; p_irw = 1; p_srcb = 2'b01; p_en = 1; end
            4'd1:  p_srcb = 2'b11;
            4'd2:  begin p_srca = 1; p_srcb = 2'b10; end
            4'd3:  begin p_mrd = 1; p_iord = 1; end
            4'd4:  begin p_rw = 1; p_m2r = 2'b01; end
            4'd5:  begin p_mwr = 1; p_iord = 1; end
            4'd6:  begin p_srca = 1; p_aop = 2'b10; end
            4'd7:  begin p_rw = 1; p_rdst = 2'b01; end
            4'd8:  begin p_srca = 1; p_aop = 2'b01; p_psrc = 2'b01; p_en = z; end
            4'd9:  begin p_srca = 1; p_aop = 2'b01; p_psrc = 2'b01; p_en = ~z; end
            4'd10: begin p_psrc = 2'b10; p_en = 1; end
            4'd11: begin p_srca = 1; p_srcb = 2'b10; end
            4'd12: p_rw = 1;
            4'd13: begin p_psrc = 2'b10; p_en = 1; p_rw = 1; p_rdst = 2'b10; p_m2r = 2'b10; end
            4'd14: begin p_psrc = 2'b11; p_en = 1; p_exc = 1; end
            default: ;
        endcase
        return {p_en, p_iord, p_mrd, p_mwr, p_irw, p_rw, p_exc,
                p_rdst, p_m2r, p_srca, p_srcb, p_aop, p_psrc};
    endfunction

    // seq lists expected states as hex nibbles, first state in the top nibble.
    task automatic run_instr(input int sel, input logic [5:0] op, input logic z,
                             input logic ov, input logic [23:0] seq, input int n,
                             input bit retire, input bit rst_last, input string name);
        exp_t e;
        logic [3:0] s;
        for (int i = 0; i < n; i++) begin
            s     = seq[23-4*i -: 4];
            e.st  = {1'b0, s};
            e.ctl = (rst_last && i == n-1) ? 18'h0 : ctl_of(s, z);
            e.ret = exp_ret[sel];
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst          = rst_last && (i == n-1);
            inst[sel]    = (i == 1 || i == 2) ? {op, 26'h0} : 32'hxxxx_xxxx;
            zero_in[sel] = z;
            ovf_in[sel]  = ov;
            #1;
            e = sb.pop_front();
            checks++;
            if (st_out[sel] !== e.st) begin
                failures++;
                $display("[TB] FAIL %s state cycle %0d: got %0d expected %0d", name, i, st_out[sel], e.st);
            end
            checks++;
            if (ctl[sel] !== e.ctl) begin
                failures++;
                $display("[TB] FAIL %s controls cycle %0d: got %b expected %b", name, i, ctl[sel], e.ctl);
            end
            checks++;
            if (ret_out[sel] !== e.ret) begin
                failures++;
                $display("[TB] FAIL %s instret cycle %0d: got %0d expected %0d", name, i, ret_out[sel], e.ret);
            end
        end
        if (retire)
            exp_ret[sel] = exp_ret[sel] + 1;
        if (rst_last) begin
            exp_ret[0] = 0;
            exp_ret[1] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (st_out[k] !== 5'd0) begin
                failures++;
                $display("[TB] FAIL reset_state dut%0d: got %0d expected 0", k, st_out[k]);
            end
            checks++;
            if (ctl[k] !== 18'h0) begin
                failures++;
                $display("[TB] FAIL reset_controls dut%0d: got %b expected 0", k, ctl[k]);
            end
            checks++;
            if (ret_out[k] !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_instret dut%0d: got %0d expected 0", k, ret_out[k]);
            end
        end
        exp_ret[0] = 0;
        exp_ret[1] = 0;
    endtask

    task automatic test_memory();
        run_instr(0, 6'b100011, 0, 0, 24'h012340, 5, 1, 0, "lw");
        run_instr(0, 6'b101011, 0, 0, 24'h012500, 4, 1, 0, "sw");
    endtask

    task automatic test_branches();
        run_instr(0, 6'b000100, 1, 0, 24'h018000, 3, 1, 0, "beq_taken");
        run_instr(0, 6'b000101, 1, 0, 24'h019000, 3, 1, 0, "bne_not_taken");
        run_instr(0, 6'b000100, 0, 0, 24'h018000, 3, 1, 0, "beq_not_taken");
        run_instr(0, 6'b000101, 0, 0, 24'h019000, 3, 1, 0, "bne_taken");
    endtask

    task automatic test_exec();
        run_instr(0, 6'b000000, 0, 0, 24'h016700, 4, 1, 0, "rtype");
        run_instr(0, 6'b001000, 0, 0, 24'h01BC00, 4, 1, 0, "addi");
    endtask

    task automatic test_traps();
        run_instr(0, 6'b001000, 0, 1, 24'h01BE00, 4, 0, 0, "addi_overflow");
        run_instr(0, 6'b000000, 0, 1, 24'h016E00, 4, 0, 0, "rtype_overflow");
        run_instr(0, 6'b111111, 0, 0, 24'h01E000, 3, 0, 0, "illegal_trap");
    endtask

    task automatic test_jumps();
        run_instr(0, 6'b000011, 0, 0, 24'h01D000, 3, 1, 0, "jal");
        run_instr(0, 6'b000010, 0, 0, 24'h01A000, 3, 1, 0, "jump");
    endtask

    task automatic test_reset_mid_lw();
        run_instr(0, 6'b100011, 0, 0, 24'h012300, 4, 0, 1, "lw_aborted");
        run_instr(0, 6'b101011, 0, 0, 24'h012500, 4, 1, 0, "sw_after_reset");
    endtask

    task automatic test_back_to_back();
        run_instr(0, 6'b000000, 0, 0, 24'h016700, 4, 1, 0, "b2b_rtype");
        run_instr(0, 6'b100011, 0, 0, 24'h012340, 5, 1, 0, "b2b_lw");
        run_instr(0, 6'b000010, 0, 0, 24'h01A000, 3, 1, 0, "b2b_jump");
    endtask

    task automatic test_trap_disabled();
        @(negedge clk);
        rst = 1'b1;
        exp_ret[0] = 0;
        exp_ret[1] = 0;
        run_instr(1, 6'b111111, 0, 0, 24'h010000, 2, 0, 0, "illegal_noop");
        run_instr(1, 6'b000101, 1, 0, 24'h010000, 2, 0, 0, "bne_disabled");
        run_instr(1, 6'b000011, 0, 0, 24'h010000, 2, 0, 0, "jal_disabled");
        run_instr(1, 6'b000000, 0, 1, 24'h016700, 4, 1, 0, "overflow_ignored");
        run_instr(1, 6'b001000, 0, 0, 24'h010000, 2, 0, 0, "addi_disabled");
        @(negedge clk);
        #1;
        checks++;
        if (st_out[1] !== 5'd0 || ret_out[1] !== exp_ret[1]) begin
            failures++;
            $display("[TB] FAIL final_basic: state %0d instret %0d expected state 0 instret %0d",
                     st_out[1], ret_out[1], exp_ret[1]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            inst[k]    = 32'h0;
            zero_in[k] = 1'b0;
            ovf_in[k]  = 1'b0;
        end
        test_reset();
        test_memory();
        test_branches();
        test_exec();
        test_traps();
        test_jumps();
        test_reset_mid_lw();
        test_back_to_back();
        test_trap_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
